// File: rtl/bit_pack_pkg.sv
// Shared types and widths for the compressor output bit packer.
package bit_pack_pkg;

  localparam int unsigned ACC_W     = 68;
  localparam int unsigned SHIFT_BIT = 6;
  localparam int unsigned CODE_W    = 34;
  localparam int unsigned OUT_W     = 32;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned FILL_W    = 7;
  localparam int unsigned LEN_W     = 6;

  typedef enum logic [1:0] {
    S_PACK  = 2'd0,
    S_EMIT  = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  // Saturate a requested code length to the widest legal code.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(CODE_W)) ? LEN_W'(CODE_W) : len;
  endfunction

endpackage

// File: rtl/bit_pack_ctrl_if.sv
// Code input stream and packed word output stream of the bit packer.
interface bit_pack_ctrl_if;
  import bit_pack_pkg::*;

  logic                i_valid;
  logic                o_ready;
  logic [CODE_W-1:0]   i_code;
  logic [LEN_W-1:0]    i_len;
  logic                i_last;
  logic                o_valid;
  logic                i_ready;
  logic [OUT_W-1:0]    o_data;
  logic                o_last;
  logic [FILL_W-1:0]   o_fill;
  logic [CNT_W-1:0]    o_word_cnt;
  logic                o_len_err;

  modport slave (
    input  i_valid, i_code, i_len, i_last, i_ready,
    output o_ready, o_valid, o_data, o_last, o_fill, o_word_cnt, o_len_err
  );

  modport master (
    output i_valid, i_code, i_len, i_last, i_ready,
    input  o_ready, o_valid, o_data, o_last, o_fill, o_word_cnt, o_len_err
  );

endinterface

// File: rtl/barrel_shifter_1.sv
// Logarithmic left barrel shifter, zero fill; purely combinational.
module barrel_shifter_1 #(
  parameter int unsigned WIDTH     = 68,
  parameter int unsigned SHIFT_BIT = 6
) (
  input  logic [WIDTH-1:0]     i_word,
  input  logic [SHIFT_BIT-1:0] i_amt,
  output logic [WIDTH-1:0]     o_word
);

  logic [WIDTH-1:0] stage [0:SHIFT_BIT];

  assign stage[0] = i_word;

  // Stage g shifts by 2**g when bit g of the amount is set.
  for (genvar g = 0; g < SHIFT_BIT; g++) begin : g_stage
    assign stage[g+1] = i_amt[g] ? (stage[g] << (2 ** g)) : stage[g];
  end

  assign o_word = stage[SHIFT_BIT];

endmodule

// File: rtl/bit_pack_ctrl.sv
// Packs variable-length codes LSB-first into 32-bit words with end-of-block
// zero-padded flush; accumulator, fill counter and FSM live here.
module bit_pack_ctrl
  import bit_pack_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  bit_pack_ctrl_if.slave   bus
);

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic                last_pend_q, last_pend_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                valid_q, valid_d;
  logic                ready_q, ready_d;
  logic [OUT_W-1:0]    data_q, data_d;
  logic                olast_q, olast_d;

  logic [LEN_W-1:0]    len_c;
  logic                len_over;
  logic [CODE_W-1:0]   code_mask;
  logic [ACC_W-1:0]    masked;
  logic [ACC_W-1:0]    shifted;
  logic [FILL_W-1:0]   pack_fill;
  logic [FILL_W-1:0]   emit_fill;

  // Code conditioning: clamp length, drop bits above it, widen to the accumulator.
  assign len_c     = clamp_len(bus.i_len);
  assign len_over  = bus.i_len > LEN_W'(CODE_W);
  assign code_mask = ~({CODE_W{1'b1}} << len_c);
  assign masked    = ACC_W'(bus.i_code & code_mask);
  assign pack_fill = fill_q + FILL_W'(len_c);
  assign emit_fill = fill_q - FILL_W'(OUT_W);

  // Fill is always below one word while packing, so its low bits are the offset.
  barrel_shifter_1 #(
    .WIDTH     (ACC_W),
    .SHIFT_BIT (SHIFT_BIT)
  ) u_shift (
    .i_word (masked),
    .i_amt  (fill_q[SHIFT_BIT-1:0]),
    .o_word (shifted)
  );

  // Next-state, datapath updates and next registered outputs.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    fill_d      = fill_q;
    last_pend_d = last_pend_q;
    cnt_d       = cnt_q;
    err_d       = err_q;

    unique case (state_q)
      S_PACK: begin
        if (bus.i_valid) begin
          if (len_over) err_d = 1'b1;
          acc_d       = acc_q | shifted;
          fill_d      = pack_fill;
          last_pend_d = bus.i_last;
          if (pack_fill >= FILL_W'(OUT_W)) begin
            state_d = S_EMIT;
          end else if (bus.i_last && (pack_fill != '0)) begin
            state_d = S_FLUSH;
          end else if (bus.i_last) begin
            cnt_d       = '0;
            last_pend_d = 1'b0;
          end
        end
      end
      S_EMIT: begin
        if (bus.i_ready) begin
          acc_d  = acc_q >> OUT_W;
          fill_d = emit_fill;
          cnt_d  = cnt_q + CNT_W'(1);
          if (emit_fill >= FILL_W'(OUT_W)) begin
            state_d = S_EMIT;
          end else if (last_pend_q && (emit_fill != '0)) begin
            state_d = S_FLUSH;
          end else if (last_pend_q) begin
            state_d     = S_PACK;
            last_pend_d = 1'b0;
            cnt_d       = '0;
          end else begin
            state_d = S_PACK;
          end
        end
      end
      S_FLUSH: begin
        if (bus.i_ready) begin
          acc_d       = '0;
          fill_d      = '0;
          last_pend_d = 1'b0;
          cnt_d       = '0;
          state_d     = S_PACK;
        end
      end
      default: state_d = S_PACK;
    endcase

    valid_d = (state_d != S_PACK);
    ready_d = (state_d == S_PACK);
    data_d  = valid_d ? acc_d[OUT_W-1:0] : '0;
    olast_d = (state_d == S_FLUSH) ||
              ((state_d == S_EMIT) && last_pend_d && (fill_d == FILL_W'(OUT_W)));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_PACK;
      acc_q       <= '0;
      fill_q      <= '0;
      last_pend_q <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      valid_q     <= 1'b0;
      ready_q     <= 1'b1;
      data_q      <= '0;
      olast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      last_pend_q <= last_pend_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      valid_q     <= valid_d;
      ready_q     <= ready_d;
      data_q      <= data_d;
      olast_q     <= olast_d;
    end
  end

  assign bus.o_ready    = ready_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_data     = data_q;
  assign bus.o_last     = olast_q;
  assign bus.o_fill     = fill_q;
  assign bus.o_word_cnt = cnt_q;
  assign bus.o_len_err  = err_q;

endmodule

// File: tb/tb_bit_pack_ctrl.sv
// Self-checking bench for bit_pack_ctrl: directed table, corner sequences,
// and random traffic scored against a bit-queue reference model.
module tb_bit_pack_ctrl;
  import bit_pack_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bit_pack_ctrl_if bus();

  bit_pack_ctrl dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
  } word_t;

  typedef struct {
    logic [33:0] code;
    logic [5:0]  len;
    logic        last;
    logic [6:0]  fill;
    logic        err;
  } vec_t;

  word_t       exp_q[$];
  word_t       got_q[$];
  logic        bq[$];
  logic [15:0] blk_words;
  logic        m_err;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    bq.delete();
    exp_q.delete();
    blk_words = '0;
    m_err     = 1'b0;
  endtask

  // Reference: the packed stream is just the concatenation of code bits.
  task automatic model_accept(input logic [33:0] code, input logic [5:0] len, input logic last);
    int    n;
    word_t w;
    n = (len > 6'd34) ? 34 : int'(len);
    if (len > 6'd34) m_err = 1'b1;
    for (int b = 0; b < n; b++) bq.push_back(code[b]);
    while (bq.size() >= 32) begin
      for (int b = 0; b < 32; b++) w.data[b] = bq.pop_front();
      w.last = last && (bq.size() == 0);
      exp_q.push_back(w);
      blk_words++;
    end
    if (last) begin
      if (bq.size() > 0) begin
        w.data = '0;
        for (int b = 0; bq.size() > 0; b++) w.data[b] = bq.pop_front();
        w.last = 1'b1;
        exp_q.push_back(w);
      end
      blk_words = '0;
    end
  endtask

  // One clock: score current outputs/handshakes, then advance to #1 after the edge.
  task automatic step();
    logic  code_acc, word_acc;
    word_t w;
    code_acc = bus.i_valid && bus.o_ready;
    word_acc = bus.o_valid && bus.i_ready;
    chk("len_err", 64'(bus.o_len_err), 64'(m_err));
    if (bus.o_ready) begin
      chk("fill", 64'(bus.o_fill), 64'(bq.size()));
      chk("word_cnt", 64'(bus.o_word_cnt), 64'(blk_words));
      chk("valid_in_pack", 64'(bus.o_valid), 64'(0));
    end
    if (word_acc) begin
      got_q.push_back('{bus.o_data, bus.o_last});
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_word: got=%08h want=none", bus.o_data);
      end else begin
        w = exp_q.pop_front();
        chk("word_data", 64'(bus.o_data), 64'(w.data));
        chk("word_last", 64'(bus.o_last), 64'(w.last));
      end
    end
    if (code_acc) model_accept(bus.i_code, bus.i_len, bus.i_last);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [33:0] code, input logic [5:0] len, input logic last);
    logic acc;
    acc         = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_code  = code;
    bus.i_len   = len;
    bus.i_last  = last;
    for (int c = 0; c < 40 && !acc; c++) begin
      acc = bus.o_ready;
      step();
    end
    chk("send_accept", 64'(acc), 64'(1));
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_ready();
    for (int c = 0; c < 20 && !bus.o_ready; c++) step();
    chk("ready_timeout", 64'(bus.o_ready), 64'(1));
  endtask

  vec_t        vt [17];
  logic [31:0] kw [7];
  logic        kl [7];

  initial begin
    rst         = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_code  = '0;
    bus.i_len   = '0;
    bus.i_last  = 1'b0;
    bus.i_ready = 1'b0;
    model_reset();

    for (int i = 0; i < 8; i++) vt[i] = '{34'hF, 6'd4, 1'b0, 7'((4 * (i + 1)) % 32), 1'b0};
    vt[8]  = '{34'hABC,         6'd12, 1'b1, 7'd0,  1'b0};
    vt[9]  = '{34'h1,           6'd31, 1'b0, 7'd31, 1'b0};
    vt[10] = '{34'h3_FFFF_FFFF, 6'd34, 1'b0, 7'd1,  1'b0};
    vt[11] = '{34'hFFFF,        6'd4,  1'b0, 7'd5,  1'b0};
    vt[12] = '{34'h3_FFFF_FFFF, 6'd40, 1'b0, 7'd7,  1'b1};
    vt[13] = '{34'h0,           6'd0,  1'b1, 7'd0,  1'b1};
    vt[14] = '{34'hFFFF,        6'd16, 1'b0, 7'd16, 1'b1};
    vt[15] = '{34'h1234,        6'd16, 1'b1, 7'd0,  1'b1};
    vt[16] = '{34'h0,           6'd0,  1'b1, 7'd0,  1'b1};
    kw[0] = 32'hFFFF_FFFF; kl[0] = 1'b0;
    kw[1] = 32'h0000_0ABC; kl[1] = 1'b1;
    kw[2] = 32'h8000_0001; kl[2] = 1'b0;
    kw[3] = 32'hFFFF_FFFF; kl[3] = 1'b0;
    kw[4] = 32'hFFFF_FFFF; kl[4] = 1'b0;
    kw[5] = 32'h0000_007F; kl[5] = 1'b1;
    kw[6] = 32'h1234_FFFF; kl[6] = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.o_valid), 64'(0));
    chk("rst_data", 64'(bus.o_data), 64'(0));
    chk("rst_last", 64'(bus.o_last), 64'(0));
    chk("rst_fill", 64'(bus.o_fill), 64'(0));
    chk("rst_cnt", 64'(bus.o_word_cnt), 64'(0));
    chk("rst_err", 64'(bus.o_len_err), 64'(0));
    chk("rst_ready", 64'(bus.o_ready), 64'(1));
    rst         = 1'b0;
    bus.i_ready = 1'b1;

    // Directed table: packing, straddling words, flush, clamp, exact-32 last.
    got_q.delete();
    for (int i = 0; i < 17; i++) begin
      send(vt[i].code, vt[i].len, vt[i].last);
      wait_ready();
      chk($sformatf("tbl%0d_fill", i), 64'(bus.o_fill), 64'(vt[i].fill));
      chk($sformatf("tbl%0d_err", i), 64'(bus.o_len_err), 64'(vt[i].err));
    end
    chk("tbl_word_count", 64'(got_q.size()), 64'(7));
    for (int i = 0; i < 7 && i < got_q.size(); i++) begin
      chk($sformatf("tbl_word%0d", i), 64'(got_q[i].data), 64'(kw[i]));
      chk($sformatf("tbl_last%0d", i), 64'(got_q[i].last), 64'(kl[i]));
    end

    // Backpressure in S_EMIT: word held, next code waits and is not lost.
    bus.i_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(34'hF, 6'd4, 1'b0);
    bus.i_valid = 1'b1;
    bus.i_code  = 34'h5;
    bus.i_len   = 6'd3;
    bus.i_last  = 1'b0;
    repeat (5) begin
      chk("bp_valid", 64'(bus.o_valid), 64'(1));
      chk("bp_data", 64'(bus.o_data), 64'(32'hFFFF_FFFF));
      chk("bp_ready", 64'(bus.o_ready), 64'(0));
      step();
    end
    bus.i_ready = 1'b1;
    send(34'h5, 6'd3, 1'b0);
    send(34'h0, 6'd0, 1'b1);
    wait_ready();
    chk("bp_tail_data", 64'(got_q[got_q.size()-1].data), 64'(32'h5));
    chk("bp_tail_last", 64'(got_q[got_q.size()-1].last), 64'(1));

    // Asynchronous reset while a word is pending discards everything.
    bus.i_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(34'hF, 6'd4, 1'b0);
    chk("pre_rst_valid", 64'(bus.o_valid), 64'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(bus.o_valid), 64'(0));
    chk("mid_rst_fill", 64'(bus.o_fill), 64'(0));
    chk("mid_rst_ready", 64'(bus.o_ready), 64'(1));
    chk("mid_rst_err", 64'(bus.o_len_err), 64'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus.i_ready = 1'b1;
    repeat (6) step();
    chk("post_rst_valid", 64'(bus.o_valid), 64'(0));

    // Random traffic against the reference model.
    for (int c = 0; c < 4000; c++) begin
      bus.i_valid = 1'($urandom_range(0, 1));
      bus.i_code  = 34'({$urandom(), $urandom()});
      bus.i_len   = 6'($urandom_range(0, 40));
      bus.i_last  = ($urandom_range(0, 9) == 0);
      bus.i_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) step();
    send(34'h0, 6'd0, 1'b1);
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) step();
    wait_ready();
    chk("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
